// File: rtl/reg128_pkg.sv
// Shared constants for the 128-bit register reader: image/word geometry and FSM encoding.
package reg128_pkg;

    localparam int unsigned DATA_W    = 128;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = DATA_W / WORD_W;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SEND = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/reg128_shadow.sv
// Shadow copy of the register image, loaded on capture and cleared by reset.
module reg128_shadow #(
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/reg128_reader.sv
// Captures a wide register image and streams it out as words, LSW first, with valid/ready.
module reg128_reader #(
    parameter int unsigned DATA_W = reg128_pkg::DATA_W,
    parameter int unsigned WORD_W = reg128_pkg::WORD_W,
    localparam int unsigned NUM_WORDS = DATA_W / WORD_W,
    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [IDX_W-1:0]  word_idx,
    output logic              last,
    output logic              done
);

    import reg128_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              load;
    logic [DATA_W-1:0] shadow;
    logic [WORD_W-1:0] word_sel;

    reg128_shadow #(
        .DATA_W (DATA_W)
    ) u_shadow (
        .clk    (clk),
        .areset (areset),
        .load   (load),
        .d      (data_in),
        .q      (shadow)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (word_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                word_sel = shadow[k*WORD_W +: WORD_W];
            end
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for an edge.
    assign word_valid = (state_q == SEND);
    assign word_out   = word_valid ? word_sel : '0;
    assign word_idx   = idx_q;
    assign last       = word_valid && (idx_q == LAST_IDX);
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule
